// File: rtl/movw_unit.sv
// Move-wide execution unit: MOVZ/MOVN/MOVK in a two-stage valid/ready pipeline, with
// forwarding of the last result so back-to-back MOVK chains to one register need no bubbles.
module movw_unit #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SH_W   = $clog2(DATA_W / IMM_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [SH_W-1:0]   in_shift,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_replacee,
  input  logic              ext_wr_valid,
  input  logic [REG_AW-1:0] ext_wr_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_err
);

  localparam logic [1:0]        OpMovz  = 2'b00;
  localparam logic [1:0]        OpMovn  = 2'b01;
  localparam logic [1:0]        OpMovk  = 2'b10;
  localparam logic [REG_AW-1:0] ZeroReg = '1;

  // Stage A: captured request
  logic              a_valid_q, a_valid_d;
  logic [1:0]        a_op_q, a_op_d;
  logic [IMM_W-1:0]  a_imm_q, a_imm_d;
  logic [SH_W-1:0]   a_shift_q, a_shift_d;
  logic [REG_AW-1:0] a_rd_q, a_rd_d;
  logic [DATA_W-1:0] a_repl_q, a_repl_d;

  // Stage B: result, drives the outputs
  logic              b_valid_q, b_valid_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic [REG_AW-1:0] b_rd_q, b_rd_d;
  logic              b_err_q, b_err_d;

  // Forward register L
  logic              l_valid_q, l_valid_d;
  logic [REG_AW-1:0] l_rd_q, l_rd_d;
  logic [DATA_W-1:0] l_data_q, l_data_d;

  logic              advance_b;
  logic              a_to_b;
  logic              accept;
  logic              fwd_hit;
  logic              l_load;
  int unsigned       pos;
  logic [DATA_W-1:0] field;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] res_data;
  logic              res_err;

  assign advance_b = !b_valid_q || out_ready;
  assign in_ready  = !reset && !flush && (!a_valid_q || advance_b);
  assign accept    = in_valid && in_ready;
  assign a_to_b    = a_valid_q && advance_b && !flush;

  assign out_valid = b_valid_q && !flush;
  assign out_data  = b_data_q;
  assign out_rd    = b_rd_q;
  assign out_err   = b_err_q;

  // Result computation for the op sitting in stage A
  always_comb begin
    pos      = 32'(a_shift_q) * IMM_W;
    field    = DATA_W'(a_imm_q) << pos;
    mask     = DATA_W'({IMM_W{1'b1}}) << pos;
    fwd_hit  = l_valid_q && (l_rd_q == a_rd_q);
    src      = fwd_hit ? l_data_q : a_repl_q;
    res_data = '0;
    res_err  = 1'b0;
    case (a_op_q)
      OpMovz:  res_data = field;
      OpMovn:  res_data = ~field;
      OpMovk:  res_data = (src & ~mask) | field;
      default: res_err  = 1'b1;
    endcase
  end

  assign l_load = a_to_b && !res_err && (a_rd_q != ZeroReg);

  always_comb begin
    a_valid_d = a_valid_q;
    a_op_d    = a_op_q;
    a_imm_d   = a_imm_q;
    a_shift_d = a_shift_q;
    a_rd_d    = a_rd_q;
    a_repl_d  = a_repl_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_rd_d    = b_rd_q;
    b_err_d   = b_err_q;
    l_valid_d = l_valid_q;
    l_rd_d    = l_rd_q;
    l_data_d  = l_data_q;

    if (a_to_b) a_valid_d = 1'b0;
    if (accept) begin
      a_valid_d = 1'b1;
      a_op_d    = in_op;
      a_imm_d   = in_imm;
      a_shift_d = in_shift;
      a_rd_d    = in_rd;
      a_repl_d  = in_replacee;
    end

    if (b_valid_q && out_ready) b_valid_d = 1'b0;
    if (a_to_b) begin
      b_valid_d = 1'b1;
      b_data_d  = res_data;
      b_rd_d    = a_rd_q;
      b_err_d   = res_err;
    end

    // The local op is younger than a coincident external write, so a load overrides it
    if (ext_wr_valid && (ext_wr_rd == l_rd_q)) l_valid_d = 1'b0;
    if (l_load) begin
      l_valid_d = 1'b1;
      l_rd_d    = a_rd_q;
      l_data_d  = res_data;
    end

    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
      l_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      a_op_q    <= '0;
      a_imm_q   <= '0;
      a_shift_q <= '0;
      a_rd_q    <= '0;
      a_repl_q  <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_rd_q    <= '0;
      b_err_q   <= 1'b0;
      l_valid_q <= 1'b0;
      l_rd_q    <= '0;
      l_data_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_op_q    <= a_op_d;
      a_imm_q   <= a_imm_d;
      a_shift_q <= a_shift_d;
      a_rd_q    <= a_rd_d;
      a_repl_q  <= a_repl_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_rd_q    <= b_rd_d;
      b_err_q   <= b_err_d;
      l_valid_q <= l_valid_d;
      l_rd_q    <= l_rd_d;
      l_data_q  <= l_data_d;
    end
  end

endmodule

// File: tb/tb_movw_unit.sv
// Directed bench for movw_unit (DATA_W=64, IMM_W=16); inputs change and outputs are sampled
// 1ns after each rising edge.
module tb_movw_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_shift = '0;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_replacee = '0;
  logic        ext_wr_valid = 1'b0;
  logic [4:0]  ext_wr_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] MOVZ = 2'b00, MOVN = 2'b01, MOVK = 2'b10, ILL = 2'b11;

  movw_unit #(.DATA_W(64), .IMM_W(16), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_imm(in_imm),
    .in_shift(in_shift), .in_rd(in_rd), .in_replacee(in_replacee),
    .ext_wr_valid(ext_wr_valid), .ext_wr_rd(ext_wr_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // packed view {valid, err, rd, data}
  logic [70:0] obs;
  assign obs = {out_valid, out_err, out_rd, out_data};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] imm, input logic [1:0] sh,
                       input logic [4:0] rd, input logic [63:0] repl);
    in_valid    = 1'b1;
    in_op       = op;
    in_imm      = imm;
    in_shift    = sh;
    in_rd       = rd;
    in_replacee = repl;
  endtask

  task automatic idle;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 71'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_state: got %h ready %b want 0 ready 1", obs, in_ready);
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    drive(MOVZ, 16'hFFFF, 2'd1, 5'd2, 64'h0);
    tick;
    drive(MOVN, 16'h1234, 2'd2, 5'd4, 64'h0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_latency: out_valid got %b want 0", out_valid);
    end
    tick;
    drive(MOVN, 16'h0000, 2'd0, 5'd5, 64'h0);
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd2, 64'h00000000FFFF0000}) begin
      errors++; $display("FAIL basic_movz: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd2, 64'h00000000FFFF0000});
    end
    tick;
    idle;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd4, 64'hFFFFEDCBFFFFFFFF}) begin
      errors++; $display("FAIL basic_movn: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd4, 64'hFFFFEDCBFFFFFFFF});
    end
    tick;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd5, 64'hFFFFFFFFFFFFFFFF}) begin
      errors++; $display("FAIL basic_movn_zero: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd5, 64'hFFFFFFFFFFFFFFFF});
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    drive(MOVK, 16'h1234, 2'd3, 5'd3, 64'hAAAAAAAAAAAAAAAA);
    tick;
    drive(MOVK, 16'h5678, 2'd0, 5'd3, 64'h0);
    tick;
    idle;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd3, 64'h1234AAAAAAAAAAAA}) begin
      errors++; $display("FAIL movk_first: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd3, 64'h1234AAAAAAAAAAAA});
    end
    tick;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd3, 64'h1234AAAAAAAA5678}) begin
      errors++; $display("FAIL movk_forward: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd3, 64'h1234AAAAAAAA5678});
    end
    tick;
  endtask

  task automatic test_invalidate;
    drive(MOVZ, 16'h0001, 2'd0, 5'd3, 64'h0);
    tick;
    idle;
    tick;
    ext_wr_valid = 1'b1;
    ext_wr_rd    = 5'd3;
    tick;
    ext_wr_valid = 1'b0;
    drive(MOVK, 16'h0000, 2'd1, 5'd3, 64'hFF00);
    tick;
    idle;
    tick;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd3, 64'h000000000000FF00}) begin
      errors++; $display("FAIL inval_no_forward: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd3, 64'h000000000000FF00});
    end
    tick;
    // external write coincident with the L load: load wins
    drive(MOVZ, 16'h0001, 2'd0, 5'd3, 64'h0);
    tick;
    idle;
    ext_wr_valid = 1'b1;
    ext_wr_rd    = 5'd3;
    tick;
    ext_wr_valid = 1'b0;
    drive(MOVK, 16'h0000, 2'd1, 5'd3, 64'hFF00);
    tick;
    idle;
    tick;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd3, 64'h0000000000000001}) begin
      errors++; $display("FAIL inval_coincident_forward: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd3, 64'h0000000000000001});
    end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(MOVZ, 16'h0001, 2'd0, 5'd6, 64'h0);
    tick;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_one_held: got %b want 1", in_ready);
    end
    drive(MOVZ, 16'h0002, 2'd0, 5'd6, 64'h0);
    tick;
    drive(MOVZ, 16'h0003, 2'd0, 5'd6, 64'h0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_full: got %b want 0", in_ready);
    end
    tick;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd6, 64'h1} || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stable: got %h ready %b want %h ready 0", obs, in_ready,
                         {1'b1, 1'b0, 5'd6, 64'h1});
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_comb: got %b want 1", in_ready);
    end
    tick;
    idle;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd6, 64'h2}) begin
      errors++; $display("FAIL bp_order2: got %h want %h", obs, {1'b1, 1'b0, 5'd6, 64'h2});
    end
    tick;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd6, 64'h3}) begin
      errors++; $display("FAIL bp_order3: got %h want %h", obs, {1'b1, 1'b0, 5'd6, 64'h3});
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_illegal;
    drive(MOVZ, 16'h0007, 2'd0, 5'd3, 64'h0);
    tick;
    drive(ILL, 16'hBEEF, 2'd1, 5'd3, 64'h0);
    tick;
    drive(MOVK, 16'h0001, 2'd1, 5'd3, 64'h0);
    tick;
    drive(MOVZ, 16'h0009, 2'd0, 5'd31, 64'h0);
    checks++;
    if (obs !== {1'b1, 1'b1, 5'd3, 64'h0}) begin
      errors++; $display("FAIL illegal_err: got %h want %h", obs, {1'b1, 1'b1, 5'd3, 64'h0});
    end
    tick;
    drive(MOVK, 16'h0000, 2'd2, 5'd3, 64'h0);
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd3, 64'h0000000000010007}) begin
      errors++; $display("FAIL illegal_keeps_l: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd3, 64'h0000000000010007});
    end
    tick;
    idle;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd31, 64'h9}) begin
      errors++; $display("FAIL zero_reg_result: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd31, 64'h9});
    end
    tick;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd3, 64'h0000000000010007}) begin
      errors++; $display("FAIL zero_reg_no_l: got %h want %h", obs,
                         {1'b1, 1'b0, 5'd3, 64'h0000000000010007});
    end
    tick;
  endtask

  // use_reset selects reset instead of flush as the clearing event
  task automatic test_clear(input bit use_reset, input logic [63:0] repl);
    out_ready = 1'b0;
    drive(MOVZ, 16'h0005, 2'd0, 5'd3, 64'h0);
    tick;
    drive(MOVZ, 16'h0006, 2'd0, 5'd3, 64'h0);
    tick;
    idle;
    if (use_reset) reset = 1'b1;
    else flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || (!use_reset && out_valid !== 1'b0)) begin
      errors++; $display("FAIL clear_cycle(reset=%0b): ready %b valid %b want 0 0",
                         use_reset, in_ready, out_valid);
    end
    tick;
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || (use_reset && obs !== 71'h0)) begin
      errors++; $display("FAIL clear_after(reset=%0b): got %h ready %b want valid 0 ready 1",
                         use_reset, obs, in_ready);
    end
    drive(MOVK, 16'h0000, 2'd1, 5'd3, repl);
    tick;
    idle;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_nothing_emitted(reset=%0b): valid %b want 0",
                         use_reset, out_valid);
    end
    tick;
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd3, repl}) begin
      errors++; $display("FAIL clear_l_cleared(reset=%0b): got %h want %h", use_reset, obs,
                         {1'b1, 1'b0, 5'd3, repl});
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_invalidate;
    test_backpressure;
    test_illegal;
    test_clear(1'b0, 64'h0000000000001111);
    test_clear(1'b1, 64'h0000000000002222);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
